// File: rtl/playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : playback_sequencer
// Function : Play/pause/stop/seek control, sample-rate divider and req/ack
//            sample fetch for the music player. Optional LOOP_PLAYBACK_EN
//            wraps to address 0 at end of track and keeps playing.
// Revision : 1.0  initial release
// ============================================================================
module playback_sequencer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 3_000,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 8,
    parameter int TRACK_LEN = 1_800_000,
    parameter int SEEK_STEP = 30_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_pause,
    input  logic              stop,
    input  logic              fwd,
    input  logic              back,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              playing,
    output logic              ended
);
    localparam int                 c_div       = CLK_HZ / SAMPLE_HZ;
    localparam int                 c_div_w     = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(c_div - 1);
    localparam logic [ADDR_W:0]    c_last_addr = (ADDR_W+1)'(TRACK_LEN - 1);
    localparam logic [ADDR_W:0]    c_seek_step = (ADDR_W+1)'(SEEK_STEP);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_play_wait = 2'd1;
    localparam logic [1:0] c_st_fetch     = 2'd2;
    localparam logic [1:0] c_st_paused    = 2'd3;

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [c_div_w-1:0] r_div;
    logic               r_pp_q, r_stop_q, r_fwd_q, r_back_q;
    logic               r_pp_pend, r_stop_pend, r_fwd_pend, r_back_pend;
    logic [DATA_W-1:0]  r_sample;
    logic               r_sample_valid;
    logic               r_ended;

    logic               w_pp_ev, w_stop_ev, w_fwd_ev, w_back_ev;
    logic               w_pp, w_stop, w_fwd, w_back;
    logic               w_tick, w_at_end;
    logic [ADDR_W:0]    w_fwd_sum;
    logic [ADDR_W-1:0]  w_fwd_addr, w_back_addr, w_addr_inc;

    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_pp_pend_nxt, w_stop_pend_nxt, w_fwd_pend_nxt, w_back_pend_nxt;
    logic               w_sample_load;
    logic               w_ended_nxt;

    assign w_pp_ev   = play_pause & ~r_pp_q;
    assign w_stop_ev = stop & ~r_stop_q;
    assign w_fwd_ev  = fwd & ~r_fwd_q;
    assign w_back_ev = back & ~r_back_q;

    assign w_pp   = w_pp_ev | r_pp_pend;
    assign w_stop = w_stop_ev | r_stop_pend;
    assign w_fwd  = w_fwd_ev | r_fwd_pend;
    assign w_back = w_back_ev | r_back_pend;

    assign w_tick     = (r_state == c_st_play_wait) && (r_div == c_div_last);
    assign w_at_end   = ({1'b0, r_addr} == c_last_addr);
    assign w_addr_inc = r_addr + ADDR_W'(1);

    // Seek arithmetic is one bit wider so the clamp sees the true sum
    assign w_fwd_sum   = {1'b0, r_addr} + c_seek_step;
    assign w_fwd_addr  = (w_fwd_sum > c_last_addr) ? c_last_addr[ADDR_W-1:0] : w_fwd_sum[ADDR_W-1:0];
    assign w_back_addr = ({1'b0, r_addr} >= c_seek_step) ? (r_addr - c_seek_step[ADDR_W-1:0]) : '0;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_pp_pend_nxt   = r_pp_pend;
        w_stop_pend_nxt = r_stop_pend;
        w_fwd_pend_nxt  = r_fwd_pend;
        w_back_pend_nxt = r_back_pend;
        w_sample_load   = 1'b0;
`ifdef LOOP_PLAYBACK_EN
        w_ended_nxt     = 1'b0;
`else
        w_ended_nxt     = r_ended;
`endif
        if (r_state == c_st_fetch) begin
            w_pp_pend_nxt   = w_pp;
            w_stop_pend_nxt = w_stop;
            w_fwd_pend_nxt  = w_fwd;
            w_back_pend_nxt = w_back;
            if (mem_ack) begin
                w_pp_pend_nxt   = 1'b0;
                w_stop_pend_nxt = 1'b0;
                if (w_stop) begin
                    w_state_nxt = c_st_idle;
                    w_addr_nxt  = '0;
                end else begin
                    w_sample_load = 1'b1;
                    w_state_nxt   = w_pp ? c_st_paused : c_st_play_wait;
                    if (w_at_end) begin
                        w_addr_nxt  = '0;
                        w_ended_nxt = 1'b1;
`ifndef LOOP_PLAYBACK_EN
                        w_state_nxt = c_st_idle;
`endif
                    end else begin
                        w_addr_nxt = w_addr_inc;
                    end
                end
            end
        end else begin
            // Pending seeks land here, after any FETCH increment; stop overrides them
            w_fwd_pend_nxt  = 1'b0;
            w_back_pend_nxt = 1'b0;
            if (w_stop_ev) begin
                w_state_nxt = c_st_idle;
                w_addr_nxt  = '0;
            end else begin
                if (w_fwd && !w_back) begin
                    w_addr_nxt = w_fwd_addr;
                end else if (w_back && !w_fwd) begin
                    w_addr_nxt = w_back_addr;
                end
                case (r_state)
                    c_st_idle: begin
                        if (w_pp_ev) begin
                            w_state_nxt = c_st_play_wait;
                            w_ended_nxt = 1'b0;
                        end
                    end
                    c_st_play_wait: begin
                        if (w_pp_ev) begin
                            w_state_nxt = c_st_paused;
                        end else if (w_tick) begin
                            w_state_nxt = c_st_fetch;
                        end
                    end
                    default: begin
                        if (w_pp_ev) begin
                            w_state_nxt = c_st_play_wait;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_addr         <= '0;
            r_div          <= '0;
            r_pp_q         <= 1'b0;
            r_stop_q       <= 1'b0;
            r_fwd_q        <= 1'b0;
            r_back_q       <= 1'b0;
            r_pp_pend      <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_fwd_pend     <= 1'b0;
            r_back_pend    <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_ended        <= 1'b0;
        end else begin
            r_pp_q         <= play_pause;
            r_stop_q       <= stop;
            r_fwd_q        <= fwd;
            r_back_q       <= back;
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_pp_pend      <= w_pp_pend_nxt;
            r_stop_pend    <= w_stop_pend_nxt;
            r_fwd_pend     <= w_fwd_pend_nxt;
            r_back_pend    <= w_back_pend_nxt;
            r_sample_valid <= w_sample_load;
            r_ended        <= w_ended_nxt;
            if (w_sample_load) begin
                r_sample <= mem_data;
            end
            // Divider keeps running through FETCH so samples stay DIV clocks apart
            case (r_state)
                c_st_idle:   r_div <= '0;
                c_st_paused: r_div <= r_div;
                default:     r_div <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
            endcase
        end
    end

    assign mem_req      = (r_state == c_st_fetch);
    assign mem_addr     = r_addr;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign playing      = (r_state == c_st_play_wait) || (r_state == c_st_fetch);
    assign ended        = r_ended;

endmodule

`default_nettype wire

// File: tb/tb_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_playback_sequencer
// Function : Directed bench for playback_sequencer with a behavioural player
//            model compared every cycle, plus hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_playback_sequencer;
    localparam int CLK_HZ    = 30_000;
    localparam int SAMPLE_HZ = 3_000;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 8;
    localparam int TRACK_LEN = 100_000;
    localparam int SEEK_STEP = 30_000;

    localparam logic [3:0] c_b_pp   = 4'b0001;
    localparam logic [3:0] c_b_fwd  = 4'b0100;
    localparam logic [3:0] c_b_back = 4'b1000;

    localparam int c_m_stopped = 0;
    localparam int c_m_run     = 1;
    localparam int c_m_paused  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              play_pause = 1'b0, stop = 1'b0, fwd = 1'b0, back = 1'b0;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] sample;
    logic              sample_valid, playing, ended;

    int errors = 0;
    int checks = 0;
    bit mem_hold = 1'b0;
    int mem_held = 0;

    // Player model state
    int                m_mode = c_m_stopped;
    int                m_phase = 0;
    int                m_addr = 0;
    bit                m_fetch = 1'b0, m_valid = 1'b0, m_ended = 1'b0;
    logic [DATA_W-1:0] m_sample = '0;
    bit                p_pp = 1'b0, p_stop = 1'b0, p_fwd = 1'b0, p_back = 1'b0;
    bit                q_pp = 1'b0, q_stop = 1'b0, q_fwd = 1'b0, q_back = 1'b0;

    playback_sequencer #(
        .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TRACK_LEN(TRACK_LEN), .SEEK_STEP(SEEK_STEP)
    ) dut (
        .clk(clk), .reset(reset), .play_pause(play_pause), .stop(stop), .fwd(fwd), .back(back),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .sample(sample), .sample_valid(sample_valid), .playing(playing), .ended(ended)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input int a);
        return DATA_W'((a * 7 + 3) ^ (a >> 8));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory answers two cycles after a request appears
    initial begin : memory
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack && !mem_hold) begin
                mem_held++;
                if (mem_held == 2) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_word(int'(mem_addr));
                    mem_held = 0;
                end
            end else begin
                mem_ack  = 1'b0;
                mem_held = 0;
            end
        end
    end

    task automatic model_reset();
        m_mode = c_m_stopped; m_phase = 0; m_addr = 0;
        m_fetch = 0; m_valid = 0; m_ended = 0; m_sample = '0;
        p_pp = 0; p_stop = 0; p_fwd = 0; p_back = 0;
        q_pp = 0; q_stop = 0; q_fwd = 0; q_back = 0;
    endtask

    task automatic model_step();
        bit e_pp, e_stop, e_fwd, e_back, f, b;
        int old_mode;
        e_pp = play_pause && !p_pp;  e_stop = stop && !p_stop;
        e_fwd = fwd && !p_fwd;       e_back = back && !p_back;
        p_pp = play_pause; p_stop = stop; p_fwd = fwd; p_back = back;
        old_mode = m_mode;
        m_valid = 0;
`ifdef LOOP_PLAYBACK_EN
        m_ended = 0;
`endif
        if (m_fetch) begin
            q_pp |= e_pp; q_stop |= e_stop; q_fwd |= e_fwd; q_back |= e_back;
            if (mem_ack) begin
                m_fetch = 0;
                if (q_stop) begin
                    m_mode = c_m_stopped;
                    m_addr = 0;
                end else begin
                    m_sample = mem_data;
                    m_valid  = 1;
                    if (m_addr == TRACK_LEN - 1) begin
                        m_addr  = 0;
                        m_ended = 1;
`ifdef LOOP_PLAYBACK_EN
                        if (q_pp) m_mode = c_m_paused;
`else
                        m_mode = c_m_stopped;
`endif
                    end else begin
                        m_addr = m_addr + 1;
                        if (q_pp) m_mode = c_m_paused;
                    end
                end
                q_pp = 0; q_stop = 0;
            end
        end else begin
            f = q_fwd || e_fwd; b = q_back || e_back;
            q_fwd = 0; q_back = 0;
            if (e_stop) begin
                m_mode = c_m_stopped;
                m_addr = 0;
            end else begin
                if (f && !b) m_addr = (m_addr + SEEK_STEP > TRACK_LEN - 1) ? TRACK_LEN - 1 : m_addr + SEEK_STEP;
                if (b && !f) m_addr = (m_addr >= SEEK_STEP) ? m_addr - SEEK_STEP : 0;
                if (e_pp) begin
                    if (m_mode == c_m_stopped) begin
                        m_mode = c_m_run;
                        m_ended = 0;
                    end else if (m_mode == c_m_run) begin
                        m_mode = c_m_paused;
                    end else begin
                        m_mode = c_m_run;
                    end
                end else if (m_mode == c_m_run && m_phase == DIV - 1) begin
                    m_fetch = 1;
                end
            end
        end
        if (old_mode == c_m_stopped) m_phase = 0;
        else if (old_mode == c_m_run) m_phase = (m_phase + 1) % DIV;
    endtask

    initial begin : model
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("cyc mem_req", mem_req, m_fetch);
            check("cyc mem_addr", mem_addr, m_addr);
            check("cyc sample", sample, m_sample);
            check("cyc sample_valid", sample_valid, m_valid);
            check("cyc playing", playing, (m_mode == c_m_run));
            check("cyc ended", ended, m_ended);
        end
    end

    task automatic press(input logic [3:0] btn);
        @(negedge clk);
        {back, fwd, stop, play_pause} = btn;
        @(negedge clk);
        {back, fwd, stop, play_pause} = 4'b0;
    endtask

    task automatic wait_for(input bit want_valid, input string what, output int n);
        logic prev, cur;
        prev = want_valid ? sample_valid : mem_req;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            cur = want_valid ? sample_valid : mem_req;
            if (cur && !prev) return;
            prev = cur;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL timeout %s: no event in %0d cycles, required within 200", what, n);
                return;
            end
        end
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, pulses;
        @(negedge clk);
        check("reset mem_req", mem_req, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset sample", sample, 0);
        check("reset sample_valid", sample_valid, 0);
        check("reset playing", playing, 0);
        check("reset ended", ended, 0);
        @(negedge clk);
        reset = 1'b0;

        press(c_b_pp);
        wait_for(0, "first req", n);
        check("first req latency", n, 10);
        check("first req addr", mem_addr, 0);
        wait_for(1, "first valid", n);
        check("req to valid", n, 2);
        check("sample addr 0", sample, mem_word(0));
        wait_for(1, "second valid", n);
        check("sample period", n, 10);
        check("sample addr 1", sample, mem_word(1));
        repeat (3) wait_for(1, "valid", n);
        check("addr after 5 samples", mem_addr, 5);

        press(c_b_pp);
        check("paused playing", playing, 0);
        press(c_b_fwd);
        check("fwd from 5", mem_addr, 30_005);
        press(c_b_pp);
        wait_for(0, "resume req", n);
        check("resume fetch addr", mem_addr, 30_005);
        wait_for(1, "resume valid", n);
        check("sample addr 30005", sample, mem_word(30_005));
        press(c_b_pp);
        press(c_b_fwd | c_b_back);
        check("fwd+back cancel", mem_addr, 30_006);
        press(c_b_back);
        check("back 30006", mem_addr, 6);
        press(c_b_back);
        check("back clamp 0", mem_addr, 0);

        press(c_b_pp);
        for (int i = 0; i < 8; i++) wait_for(0, "req to 7", n);
        check("stop fetch addr", mem_addr, 7);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("req held after stop", mem_req, 1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (sample_valid) pulses++;
        end
        check("valid after stop", pulses, 0);
        check("stop playing", playing, 0);
        check("stop addr", mem_addr, 0);
        check("stop sample kept", sample, mem_word(6));

        press(c_b_fwd);
        press(c_b_fwd);
        check("fwd 60000", mem_addr, 60_000);
        press(c_b_fwd);
        press(c_b_fwd);
        check("fwd clamp", mem_addr, TRACK_LEN - 1);
        press(c_b_pp);
        wait_for(0, "last req", n);
        check("last fetch addr", mem_addr, 99_999);
        wait_for(1, "last valid", n);
        check("last sample", sample, mem_word(99_999));
        check("ended at end", ended, 1);
        check("addr wrap", mem_addr, 0);
`ifdef LOOP_PLAYBACK_EN
        check("loop playing", playing, 1);
        @(negedge clk);
        check("ended pulse", ended, 0);
        wait_for(0, "loop req", n);
        check("loop req addr", mem_addr, 0);
`else
        check("end playing", playing, 0);
        repeat (3) @(negedge clk);
        check("ended sticky", ended, 1);
        press(c_b_pp);
        check("ended cleared", ended, 0);
        check("replay playing", playing, 1);
`endif

        mem_hold = 1'b1;
        if (!mem_req) wait_for(0, "hold req", n);
        repeat (3) @(negedge clk);
        check("req held without ack", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("async req drop", mem_req, 0);
        check("async playing drop", playing, 0);
        @(negedge clk);
        mem_hold = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post reset addr", mem_addr, 0);
        check("post reset req", mem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
